// File: rtl/ohsm.sv
// One-hot four-state step sequencer with a global step counter.
// A rising edge on start advances S1->S2->S3->S4->S1; corrupted state codes recover to S1.
module ohsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] ValorEstado,
  output logic [3:0] SGlobal
);

  typedef enum logic [3:0] {
    S1 = 4'b0001,
    S2 = 4'b0010,
    S3 = 4'b0100,
    S4 = 4'b1000
  } state_e;

  // The state register is plain logic so that any 4-bit pattern, legal or not, can be represented.
  logic [3:0] state_q;
  logic [3:0] cnt_q;
  logic       start_q;
  logic       step_s;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  assign step_s = start & ~start_q;

  // Edge-detect register, state sequencing with illegal-code recovery, and step counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q <= 1'b0;
      state_q <= S1;
      cnt_q   <= 4'd0;
    end else begin
      start_q <= start;
      if (!is_onehot(state_q)) begin
        state_q <= S1;
        cnt_q   <= cnt_q;
      end else if (step_s) begin
        cnt_q <= cnt_q + 4'd1;
        case (state_q)
          S1:      state_q <= S2;
          S2:      state_q <= S3;
          S3:      state_q <= S4;
          S4:      state_q <= S1;
          default: state_q <= S1;
        endcase
      end else begin
        state_q <= state_q;
        cnt_q   <= cnt_q;
      end
    end
  end

  assign ValorEstado = state_q;
  assign SGlobal     = cnt_q;

endmodule

// File: tb/tb_ohsm.sv
// Directed self-checking bench for ohsm.
module tb_ohsm;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] ValorEstado;
  logic [3:0] SGlobal;

  int checks = 0;
  int errors = 0;

  ohsm dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ValorEstado (ValorEstado),
    .SGlobal     (SGlobal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Assert reset for two cycles, release at a falling edge.
  task automatic do_reset();
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One-cycle start pulse followed by one idle cycle; starts and ends at a falling edge.
  task automatic pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ValorEstado !== 4'b0001) begin
      errors++;
      $display("FAIL reset_state got=%b exp=0001", ValorEstado);
    end
    checks++;
    if (SGlobal !== 4'b0000) begin
      errors++;
      $display("FAIL reset_cnt got=%b exp=0000", SGlobal);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (ValorEstado !== 4'b0001 || SGlobal !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%b/%b exp=0001/0000", i, ValorEstado, SGlobal);
      end
    end
  endtask

  task automatic test_full_lap();
    logic [3:0] exp_st [4];
    exp_st = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pulse();
      checks++;
      if (ValorEstado !== exp_st[i] || SGlobal !== 4'(i + 1)) begin
        errors++;
        $display("FAIL full_lap step=%0d got=%b/%b exp=%b/%b",
                 i, ValorEstado, SGlobal, exp_st[i], 4'(i + 1));
      end
    end
  endtask

  task automatic test_held_start();
    do_reset();
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (ValorEstado !== 4'b0010 || SGlobal !== 4'd1) begin
        errors++;
        $display("FAIL held_start cyc=%0d got=%b/%b exp=0010/0001", i, ValorEstado, SGlobal);
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (ValorEstado !== 4'b0010 || SGlobal !== 4'd1) begin
      errors++;
      $display("FAIL held_release got=%b/%b exp=0010/0001", ValorEstado, SGlobal);
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int i = 0; i < 15; i++) pulse();
    checks++;
    if (ValorEstado !== 4'b1000 || SGlobal !== 4'b1111) begin
      errors++;
      $display("FAIL wrap_pre got=%b/%b exp=1000/1111", ValorEstado, SGlobal);
    end
    pulse();
    checks++;
    if (ValorEstado !== 4'b0001 || SGlobal !== 4'b0000) begin
      errors++;
      $display("FAIL wrap got=%b/%b exp=0001/0000", ValorEstado, SGlobal);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    pulse();
    pulse();
    checks++;
    if (ValorEstado !== 4'b0100 || SGlobal !== 4'd2) begin
      errors++;
      $display("FAIL mid_reset_pre got=%b/%b exp=0100/0010", ValorEstado, SGlobal);
    end
    start = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (ValorEstado !== 4'b0001 || SGlobal !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_async got=%b/%b exp=0001/0000", ValorEstado, SGlobal);
    end
    @(negedge clk);
    checks++;
    if (ValorEstado !== 4'b0001 || SGlobal !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_held got=%b/%b exp=0001/0000", ValorEstado, SGlobal);
    end
    start = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_start_high_at_release();
    start = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ValorEstado !== 4'b0010 || SGlobal !== 4'd1) begin
      errors++;
      $display("FAIL start_at_release got=%b/%b exp=0010/0001", ValorEstado, SGlobal);
    end
    @(negedge clk);
    checks++;
    if (ValorEstado !== 4'b0010 || SGlobal !== 4'd1) begin
      errors++;
      $display("FAIL start_at_release_hold got=%b/%b exp=0010/0001", ValorEstado, SGlobal);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_illegal_state();
    do_reset();
    pulse();
    force dut.state_q = 4'b0110;
    #1;
    release dut.state_q;
    #1;
    checks++;
    if (ValorEstado !== 4'b0110) begin
      errors++;
      $display("FAIL illegal_inject got=%b exp=0110", ValorEstado);
    end
    @(negedge clk);
    checks++;
    if (ValorEstado !== 4'b0001 || SGlobal !== 4'd1) begin
      errors++;
      $display("FAIL illegal_recover got=%b/%b exp=0001/0001", ValorEstado, SGlobal);
    end
    // All-zero code with a start rising edge present: recovery wins and the counter holds.
    force dut.state_q = 4'b0000;
    #1;
    release dut.state_q;
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (ValorEstado !== 4'b0001 || SGlobal !== 4'd1) begin
      errors++;
      $display("FAIL zero_recover got=%b/%b exp=0001/0001", ValorEstado, SGlobal);
    end
    start = 1'b0;
    @(negedge clk);
    pulse();
    checks++;
    if (ValorEstado !== 4'b0010 || SGlobal !== 4'd2) begin
      errors++;
      $display("FAIL post_recover_step got=%b/%b exp=0010/0010", ValorEstado, SGlobal);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    test_reset();
    test_full_lap();
    test_held_start();
    test_counter_wrap();
    test_mid_reset();
    test_start_high_at_release();
    test_illegal_state();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
